draw_sprite_layer: RTL and testbench
====================================

Name: draw_sprite_layer

Overview:
Parametrised sprite compositor stage for the VGA draw chain. It replaces the per-character fixed draw stages with one block that overlays NUM_SPR animated sprites on the incoming vga_if stream. Each sprite has its own ROM read port, a shadowed position and enable, and its own animation frame. It sits between draw_background and the HUD stages (hp, power, mouse).

Parameters:
NUM_SPR, 4, number of sprites and ROM read ports
SPR_W, 32, sprite width in pixels
SPR_H, 32, sprite height in pixels
FRAMES, 4, animation frames per sprite, stored consecutively in each sprite's ROM
FRAME_DIV, 8, vsync periods per animation step (>=1)
ADDR_W, 12, ROM address width
TRANSPARENT, 12'h0F0, key colour that is never drawn

Ports:
clk60MHz  in  1  system clock
rst  in  1  asynchronous reset, active-low
spr_xpos  in  NUM_SPR*12  left edge per sprite, sprite i at bits [12*i +: 12]
spr_ypos  in  NUM_SPR*12  top edge per sprite
spr_en  in  NUM_SPR  sprite visible
spr_anim_en  in  NUM_SPR  animation running
pixel_addr  out  NUM_SPR*ADDR_W  ROM address per sprite
rgb_pixel  in  NUM_SPR*12  ROM data per sprite, one-cycle synchronous read
in  vga_if  -  timing, counters and rgb from the previous stage
out  vga_if  -  delayed timing and composited rgb

Behaviour:
- Reset (rst=0, async):
  - out: all fields 0; pixel_addr 0.
  - Shadow x/y/en/anim_en cleared to 0; vsync divider 0; every frame index 0.
- Shadowing:
  - On the rising edge of in.vsync (in.vsync=1 while its previous-cycle value was 0), latch spr_xpos, spr_ypos, spr_en and spr_anim_en into the shadow registers.
  - Input changes mid-frame take effect only at the next vsync rise.
- Animation:
  - The divider counts vsync rises 0..FRAME_DIV-1.
  - On wrap, each sprite with shadow anim_en=1 advances frame = (frame+1) mod FRAMES.
  - A sprite with anim_en=0 holds frame 0.
  - The divider update and the shadow latch occur on the same vsync rise; the frame advance uses the newly latched anim_en.
- Hit test (stage 1, registered):
  - Sprite i hits when shadow en=1, in.hblnk=0, in.vblnk=0, x <= hcount < x+SPR_W and y <= vcount < y+SPR_H.
  - Compare in 13 bits so that x+SPR_W and y+SPR_H never wrap. A sprite near the right/bottom edge is clipped; it never reappears at the left/top.
- Address:
  - pixel_addr_i = frame_i*SPR_W*SPR_H + (vcount-y)*SPR_W + (hcount-x), registered one clock after in.
  - On a miss, pixel_addr_i holds 0.
- Pipeline:
  - Stage 1: hit, address and a copy of in are registered.
  - Stage 2: ROM data appears and hit/timing are delayed once more.
  - Stage 3: out is registered.
  - Total in-to-out latency is exactly 3 clocks. vcount, hcount, vsync, hsync, vblnk and hblnk are delayed identically.
- Composite (stage 3):
  - The lowest index i with hit and rgb_pixel_i != TRANSPARENT wins.
  - If no sprite qualifies, out.rgb = in.rgb delayed 3 clocks.
  - During blanking, out.rgb is the delayed in.rgb, unchanged.
- Overlap is resolved per pixel; transparent pixels of a higher-priority sprite fall through to lower-priority sprites.
- Reset released mid-frame: compositing restarts immediately. Positions stay 0/disabled until the first vsync rise.
- Elaboration: $error if FRAMES*SPR_W*SPR_H > 2**ADDR_W or FRAME_DIV < 1.

Decomposition:
- Shared package: the 12-bit coordinate type, the 12-bit rgb type, the TRANSPARENT default colour constant and the visible-area constants (1024x768).
- One sub-module, sprite_hit_addr:
  - Instantiated per sprite in a generate loop.
  - Inputs: shadow position/en/frame plus counters.
  - Outputs: registered hit and address.
  - Keeps the top block to shadowing, animation counters, delay line and priority mux.

Test Plan:
1. Reset behaviour: assert rst=0 at hcount=500 -> out.rgb, out.hsync, out.vsync and pixel_addr are 0 on the same cycle. Release rst -> sprites stay invisible until the first vsync rise.
2. Address and latency: sprite0 at (100,200), en=1; the ROM model returns the address as colour.
   - At vcount=200, hcount=100 -> pixel_addr0=0 one clock later and out.rgb=12'h000 three clocks later.
   - At hcount=131 -> address 31.
   - At hcount=132 -> background passes.
   - At vcount=201, hcount=100 -> address 32.
3. Priority and transparency: sprite0 and sprite1 both at (300,300); sprite0 ROM returns 12'h0F0 at address 5 and 12'hF00 elsewhere; sprite1 returns 12'h00F.
   - At hcount=305 -> out 12'h00F.
   - At hcount=306 -> out 12'hF00.
4. Animation: FRAME_DIV=8, anim_en=1.
   - After 8 vsync rises the base address is 1024; after 24 it is 3072; after 32 it wraps to 0.
   - Clear anim_en -> base 0 from the next vsync onward.
5. Shadowing: move sprite0 from y=200 to y=400 while vcount=100 -> the current frame still draws at y=200; the next frame draws at y=400.
6. Clipping: x=1010 -> sprite drawn at hcount 1010..1023 only, with no pixels at hcount 0..17. y=760 -> drawn at rows 760..767 only, nothing at the top rows.

Source files
------------

// File: rtl/draw_sprite_layer_pkg.sv
// Shared types and constants for the sprite compositor stage of the VGA draw chain.
package draw_sprite_layer_pkg;

   typedef logic [11:0] coord_t;
   typedef logic [11:0] rgb_t;

   localparam rgb_t        TRANSPARENT_RGB = 12'h0F0;
   localparam int unsigned H_VISIBLE       = 1024;
   localparam int unsigned V_VISIBLE       = 768;

   typedef struct packed {
      coord_t vcount;
      logic   vsync;
      logic   vblnk;
      coord_t hcount;
      logic   hsync;
      logic   hblnk;
      rgb_t   rgb;
   } vga_t;

endpackage

// File: rtl/draw_sprite_layer_hit_addr.sv
// Per-sprite hit test and ROM address generation, registered one clock after the counters.
module sprite_hit_addr
   import draw_sprite_layer_pkg::*;
#(
   parameter int unsigned SPR_W   = 32,
   parameter int unsigned SPR_H   = 32,
   parameter int unsigned ADDR_W  = 12,
   parameter int unsigned FRAME_W = 2
) (
   input  logic               clk60MHz,
   input  logic               rst,
   input  coord_t             spr_x,
   input  coord_t             spr_y,
   input  logic               spr_en,
   input  logic [FRAME_W-1:0] frame,
   input  coord_t             hcount,
   input  coord_t             vcount,
   input  logic               hblnk,
   input  logic               vblnk,
   output logic               hit_q,
   output logic [ADDR_W-1:0]  addr_q
);

   logic              hit_d;
   logic [ADDR_W-1:0] addr_d;
   logic [12:0]       h13, v13, x13, y13;
   logic [31:0]       dx, dy, base;

   always_comb begin
      // 13-bit compare so the far edge never wraps back to column/row 0
      h13   = {1'b0, hcount};
      v13   = {1'b0, vcount};
      x13   = {1'b0, spr_x};
      y13   = {1'b0, spr_y};
      hit_d = spr_en && !hblnk && !vblnk &&
              (h13 >= x13) && (h13 < x13 + 13'(SPR_W)) &&
              (v13 >= y13) && (v13 < y13 + 13'(SPR_H));
      dx     = 32'(coord_t'(hcount - spr_x));
      dy     = 32'(coord_t'(vcount - spr_y));
      base   = 32'(frame) * SPR_W * SPR_H;
      addr_d = hit_d ? ADDR_W'(base + dy * SPR_W + dx) : '0;
   end

   always_ff @(posedge clk60MHz or negedge rst) begin
      if (!rst) begin
         hit_q  <= 1'b0;
         addr_q <= '0;
      end else begin
         hit_q  <= hit_d;
         addr_q <= addr_d;
      end
   end

endmodule

// File: rtl/draw_sprite_layer.sv
// Overlays NUM_SPR animated sprites on the vga stream with a fixed 3-clock latency.
module draw_sprite_layer
   import draw_sprite_layer_pkg::*;
#(
   parameter int unsigned NUM_SPR     = 4,
   parameter int unsigned SPR_W       = 32,
   parameter int unsigned SPR_H       = 32,
   parameter int unsigned FRAMES      = 4,
   parameter int unsigned FRAME_DIV   = 8,
   parameter int unsigned ADDR_W      = 12,
   parameter rgb_t        TRANSPARENT = TRANSPARENT_RGB
) (
   input  logic                      clk60MHz,
   input  logic                      rst,
   input  logic [NUM_SPR*12-1:0]     spr_xpos,
   input  logic [NUM_SPR*12-1:0]     spr_ypos,
   input  logic [NUM_SPR-1:0]        spr_en,
   input  logic [NUM_SPR-1:0]        spr_anim_en,
   output logic [NUM_SPR*ADDR_W-1:0] pixel_addr,
   input  logic [NUM_SPR*12-1:0]     rgb_pixel,
   input  vga_t                      in,
   output vga_t                      out
);

   localparam int unsigned FRAME_W = (FRAMES > 1) ? $clog2(FRAMES) : 1;
   localparam int unsigned DIV_W   = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

   if (FRAMES * SPR_W * SPR_H > (1 << ADDR_W)) begin : g_err_rom
      $error("sprite frames do not fit in the ROM address space");
   end
   if (FRAME_DIV < 1) begin : g_err_div
      $error("FRAME_DIV must be at least 1");
   end

   logic               vsync_prev_q;
   logic [DIV_W-1:0]   div_q, div_d;
   coord_t             x_q [NUM_SPR];
   coord_t             x_d [NUM_SPR];
   coord_t             y_q [NUM_SPR];
   coord_t             y_d [NUM_SPR];
   logic [FRAME_W-1:0] frame_q [NUM_SPR];
   logic [FRAME_W-1:0] frame_d [NUM_SPR];
   logic [NUM_SPR-1:0] en_q, en_d, anim_q, anim_d;
   logic [NUM_SPR-1:0] hit1, hit2_q;
   vga_t               vga1_q, vga2_q, out_q, out_d;
   logic               vs_rise, div_wrap;

   always_comb begin
      vs_rise  = in.vsync & ~vsync_prev_q;
      div_wrap = (div_q == DIV_W'(FRAME_DIV - 1));
      div_d    = div_q;
      x_d      = x_q;
      y_d      = y_q;
      en_d     = en_q;
      anim_d   = anim_q;
      frame_d  = frame_q;
      if (vs_rise) begin
         div_d  = div_wrap ? '0 : div_q + 1'b1;
         en_d   = spr_en;
         anim_d = spr_anim_en;
         for (int i = 0; i < NUM_SPR; i++) begin
            x_d[i] = spr_xpos[12*i +: 12];
            y_d[i] = spr_ypos[12*i +: 12];
            // Frame advance follows the anim_en being latched on this same rise
            if (!spr_anim_en[i]) begin
               frame_d[i] = '0;
            end else if (div_wrap) begin
               frame_d[i] = (frame_q[i] == FRAME_W'(FRAMES - 1)) ? '0 : frame_q[i] + 1'b1;
            end
         end
      end
   end

   for (genvar g = 0; g < NUM_SPR; g++) begin : g_spr
      sprite_hit_addr #(
         .SPR_W  (SPR_W),
         .SPR_H  (SPR_H),
         .ADDR_W (ADDR_W),
         .FRAME_W(FRAME_W)
      ) u_hit_addr (
         .clk60MHz(clk60MHz),
         .rst     (rst),
         .spr_x   (x_q[g]),
         .spr_y   (y_q[g]),
         .spr_en  (en_q[g]),
         .frame   (frame_q[g]),
         .hcount  (in.hcount),
         .vcount  (in.vcount),
         .hblnk   (in.hblnk),
         .vblnk   (in.vblnk),
         .hit_q   (hit1[g]),
         .addr_q  (pixel_addr[ADDR_W*g +: ADDR_W])
      );
   end

   // Walk from highest to lowest index so the lowest opaque sprite is written last
   always_comb begin
      out_d = vga2_q;
      for (int i = 0; i < NUM_SPR; i++) begin
         if (hit2_q[NUM_SPR-1-i] && (rgb_pixel[12*(NUM_SPR-1-i) +: 12] != TRANSPARENT)) begin
            out_d.rgb = rgb_pixel[12*(NUM_SPR-1-i) +: 12];
         end
      end
   end

   always_ff @(posedge clk60MHz or negedge rst) begin
      if (!rst) begin
         vsync_prev_q <= 1'b0;
         div_q        <= '0;
         en_q         <= '0;
         anim_q       <= '0;
         for (int i = 0; i < NUM_SPR; i++) begin
            x_q[i]     <= '0;
            y_q[i]     <= '0;
            frame_q[i] <= '0;
         end
         vga1_q <= '0;
         vga2_q <= '0;
         hit2_q <= '0;
         out_q  <= '0;
      end else begin
         vsync_prev_q <= in.vsync;
         div_q        <= div_d;
         en_q         <= en_d;
         anim_q       <= anim_d;
         x_q          <= x_d;
         y_q          <= y_d;
         frame_q      <= frame_d;
         vga1_q       <= in;
         vga2_q       <= vga1_q;
         hit2_q       <= hit1;
         out_q        <= out_d;
      end
   end

   assign out = out_q;

endmodule

// File: tb/tb_draw_sprite_layer.sv
// Randomised bench for draw_sprite_layer against a pixel-level reference model with a ROM model.
module tb_draw_sprite_layer;
   import draw_sprite_layer_pkg::*;

   localparam int NS = 4;
   localparam int SW = 32;
   localparam int SH = 32;
   localparam int FR = 4;
   localparam int FD = 8;
   localparam int AW = 12;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic [NS*12-1:0] spr_xpos = '0;
   logic [NS*12-1:0] spr_ypos = '0;
   logic [NS-1:0]    spr_en = '0;
   logic [NS-1:0]    spr_anim_en = '0;
   logic [NS*AW-1:0] pixel_addr;
   logic [NS*12-1:0] rgb_pixel;
   vga_t             vin = '0;
   vga_t             vout;

   logic [AW-1:0] rom_addr_q [NS];
   int            rom_mode = 0;
   int            checks = 0;
   int            failures = 0;

   // reference model state
   int          m_x [NS];
   int          m_y [NS];
   int          m_frame [NS];
   bit          m_en [NS];
   bit          m_anim [NS];
   int          m_rises;
   bit          m_prev;
   int          exp_addr [NS];
   logic [39:0] exp_q [$];

   draw_sprite_layer #(
      .NUM_SPR  (NS),
      .SPR_W    (SW),
      .SPR_H    (SH),
      .FRAMES   (FR),
      .FRAME_DIV(FD),
      .ADDR_W   (AW)
   ) dut (
      .clk60MHz   (clk),
      .rst        (rst),
      .spr_xpos   (spr_xpos),
      .spr_ypos   (spr_ypos),
      .spr_en     (spr_en),
      .spr_anim_en(spr_anim_en),
      .pixel_addr (pixel_addr),
      .rgb_pixel  (rgb_pixel),
      .in         (vin),
      .out        (vout)
   );

   always #5 clk = ~clk;

   function automatic logic [11:0] rom_color(input int mode, input int i, input int a);
      if (mode == 1) begin
         if (i == 0) return (a == 5) ? 12'h0F0 : 12'hF00;
         if (i == 1) return 12'h00F;
         return 12'(a);
      end
      if (mode == 2) begin
         if (a % 5 == i) return 12'h0F0;
         return 12'(a * 7 + i * 'h321);
      end
      return 12'(a + i * 'h321);
   endfunction

   // synchronous-read ROMs, one per sprite
   always @(posedge clk) begin
      for (int i = 0; i < NS; i++) rom_addr_q[i] <= pixel_addr[AW*i +: AW];
   end

   always_comb begin
      rgb_pixel = '0;
      for (int i = 0; i < NS; i++) rgb_pixel[12*i +: 12] = rom_color(rom_mode, i, int'(rom_addr_q[i]));
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s at t=%0t: got %0h expected %0h", tag, $time, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < NS; i++) begin
         m_x[i] = 0; m_y[i] = 0; m_frame[i] = 0; m_en[i] = 0; m_anim[i] = 0; exp_addr[i] = 0;
      end
      m_rises = 0;
      m_prev  = 0;
      exp_q.delete();
   endtask

   task automatic model_step();
      int          h, v;
      bit          hit, done;
      logic [11:0] rgb, c;
      h    = int'(vin.hcount);
      v    = int'(vin.vcount);
      rgb  = vin.rgb;
      done = 0;
      for (int i = 0; i < NS; i++) begin
         hit = m_en[i] && !vin.hblnk && !vin.vblnk && h >= m_x[i] && h < m_x[i] + SW &&
               v >= m_y[i] && v < m_y[i] + SH;
         exp_addr[i] = hit ? m_frame[i] * SW * SH + (v - m_y[i]) * SW + (h - m_x[i]) : 0;
         c = rom_color(rom_mode, i, exp_addr[i]);
         if (hit && !done && c != TRANSPARENT_RGB) begin
            rgb  = c;
            done = 1;
         end
      end
      exp_q.push_back({vin.vcount, vin.hcount, vin.vsync, vin.hsync, vin.vblnk, vin.hblnk, rgb});
      if (vin.vsync && !m_prev) begin
         m_rises++;
         for (int i = 0; i < NS; i++) begin
            m_x[i]    = int'(spr_xpos[12*i +: 12]);
            m_y[i]    = int'(spr_ypos[12*i +: 12]);
            m_en[i]   = spr_en[i];
            m_anim[i] = spr_anim_en[i];
            if (!m_anim[i]) m_frame[i] = 0;
            else if (m_rises % FD == 0) m_frame[i] = (m_frame[i] + 1) % FR;
         end
      end
      m_prev = vin.vsync;
   endtask

   task automatic check_outputs();
      logic [39:0] e;
      for (int i = 0; i < NS; i++)
         check_eq($sformatf("pixel_addr%0d", i), 32'(pixel_addr[AW*i +: AW]), 32'(exp_addr[i]));
      if (exp_q.size() == 3) begin
         e = exp_q.pop_front();
         check_eq("out_timing", 32'({vout.vcount, vout.hcount, vout.vsync, vout.hsync,
                                      vout.vblnk, vout.hblnk}), 32'(e[39:12]));
         check_eq("out_rgb", 32'(vout.rgb), 32'(e[11:0]));
      end
   endtask

   task automatic px(input int h, input int v, input bit hs, input bit vs, input bit hb,
                     input bit vb);
      vin.hcount = 12'(h);
      vin.vcount = 12'(v);
      vin.hsync  = hs;
      vin.vsync  = vs;
      vin.hblnk  = hb;
      vin.vblnk  = vb;
      vin.rgb    = 12'($urandom);
      model_step();
      @(posedge clk);
      @(negedge clk);
      check_outputs();
   endtask

   task automatic row(input int v, input int h0, input int h1);
      for (int h = h0; h <= h1; h++) px(h, v, 0, 0, 0, 0);
   endtask

   task automatic vsync_pulse();
      px(0, 770, 0, 1, 1, 1);
      px(1, 770, 0, 0, 1, 1);
   endtask

   task automatic set_spr(input int i, input int x, input int y, input bit en, input bit anim);
      spr_xpos[12*i +: 12] = 12'(x);
      spr_ypos[12*i +: 12] = 12'(y);
      spr_en[i]            = en;
      spr_anim_en[i]       = anim;
   endtask

   // blank pixels drain the pipeline before the ROM contents are swapped
   task automatic set_mode(input int m);
      repeat (3) px(0, 780, 0, 0, 1, 1);
      rom_mode = m;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      repeat (2) @(negedge clk);
      model_reset();
      rst = 1'b1;
   endtask

   initial begin
      model_reset();
      do_reset();

      // sprite0 programmed but invisible until the first vsync rise
      set_spr(0, 100, 200, 1, 0);
      row(200, 95, 140);
      vsync_pulse();
      row(200, 95, 140);
      row(201, 98, 104);

      // asynchronous reset mid-line
      for (int h = 490; h < 500; h++) px(h, 201, 1, 0, 0, 0);
      vin.hcount = 12'd500;
      rst = 1'b0;
      #1;
      check_eq("rst_out_rgb", 32'(vout.rgb), 32'h0);
      check_eq("rst_out_hsync", 32'(vout.hsync), 32'h0);
      check_eq("rst_out_vsync", 32'(vout.vsync), 32'h0);
      check_eq("rst_pixel_addr", 32'(pixel_addr), 32'h0);
      @(negedge clk);
      @(negedge clk);
      model_reset();
      rst = 1'b1;
      row(200, 95, 110);
      vsync_pulse();
      row(200, 95, 110);

      // priority and transparency between two stacked sprites
      set_mode(1);
      set_spr(0, 300, 300, 1, 0);
      set_spr(1, 300, 300, 1, 0);
      vsync_pulse();
      row(300, 298, 310);
      row(301, 330, 333);
      set_spr(1, 0, 0, 0, 0);
      set_mode(0);

      // animation: frame advances every FD vsync rises, wraps after FR frames
      do_reset();
      set_spr(0, 100, 200, 1, 1);
      for (int k = 1; k <= 33; k++) begin
         vsync_pulse();
         row(200, 100, 101);
      end
      set_spr(0, 100, 200, 1, 0);
      vsync_pulse();
      row(200, 100, 101);

      // shadowing: mid-frame move takes effect at the next vsync
      set_spr(0, 100, 200, 1, 0);
      vsync_pulse();
      row(100, 100, 102);
      set_spr(0, 100, 400, 1, 0);
      row(200, 100, 103);
      row(400, 100, 103);
      vsync_pulse();
      row(200, 100, 103);
      row(400, 100, 103);

      // clipping at the right and bottom edges
      set_spr(0, 1010, 200, 1, 0);
      vsync_pulse();
      row(200, 1005, 1023);
      row(201, 0, 20);
      set_spr(0, 500, 760, 1, 0);
      vsync_pulse();
      row(766, 498, 503);
      row(767, 498, 503);
      row(0, 498, 503);
      row(5, 498, 503);

      // randomised frames with all sprites and transparent ROM pixels
      set_mode(2);
      for (int f = 0; f < 12; f++) begin
         for (int i = 0; i < NS; i++)
            set_spr(i, int'($urandom_range(0, 130)), int'($urandom_range(0, 50)),
                    bit'($urandom_range(0, 3) != 0), bit'($urandom_range(0, 1)));
         vsync_pulse();
         for (int r = 0; r < 5; r++) begin
            int v0, h0;
            v0 = int'($urandom_range(0, 90));
            h0 = int'($urandom_range(0, 120));
            if (r == 2) set_spr(int'($urandom_range(0, NS - 1)), int'($urandom_range(0, 130)),
                                int'($urandom_range(0, 50)), 1, 1);
            for (int h = h0; h < h0 + 40; h++) px(h, v0, 0, 0, bit'($urandom_range(0, 15) == 0), 0);
         end
      end
      set_mode(0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
